wr_ptr_full_ctrl: RTL and testbench
===================================

// Module: wr_ptr_full_ctrl
// PURPOSE
//  Write-side pointer and full-flag controller for the processor->UART async FIFO; parametrised successor of the fixed-width full comparator.
//  Owns the write pointer and synchronises the read-domain Gray pointer through SYNC_STAGES flops.
//  Produces registered full / almost_full / level flags plus a sticky overflow flag.
//  Uses an extra wrap bit so full and empty are distinct; sits entirely in the uart_clk domain.
// PARAMETERS
//  ADDR_WIDTH   4  FIFO address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  SYNC_STAGES  2  flops in the Gray-pointer synchroniser; legal range 2..4
//  AFULL_THRESH 2  almost_full asserts when free slots <= AFULL_THRESH; must satisfy 1 <= AFULL_THRESH < DEPTH
// PORTS
//  uart_clk     in   1             sole clock
//  reset        in   1             asynchronous, active-low reset
//  wr_en        in   1             write request from producer
//  ovf_clr      in   1             clears sticky overflow
//  r_ptr_gray   in   ADDR_WIDTH+1  read pointer, Gray coded, registered in the read domain
//  wr_accept    out  1             wr_en & ~full (combinational); memory write strobe
//  w_addr       out  ADDR_WIDTH    memory write address = w_ptr_bin[ADDR_WIDTH-1:0]
//  w_ptr_gray   out  ADDR_WIDTH+1  registered Gray write pointer, for the read-domain synchroniser
//  full         out  1             registered full flag
//  almost_full  out  1             registered almost-full flag
//  level        out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH
//  overflow     out  1             sticky: a write was attempted while full
// BEHAVIOUR
//  - Reset (reset=0, async): w_ptr_bin, w_ptr_gray, all sync flops, full, almost_full, level and overflow are 0.
//    w_addr is 0 and wr_accept is 0.
//  - Synchroniser: r_ptr_gray shifts through SYNC_STAGES flops. The final stage is converted Gray->bin to give rptr_sync.
//    r_ptr_gray is assumed to change at most one bit per read-domain cycle; this block does not check that.
//  - Write: if wr_accept=1, w_ptr_bin <= w_ptr_bin+1, mod 2**(ADDR_WIDTH+1).
//    w_ptr_gray <= bin2gray of the incremented value, in the same edge.
//  - Wrap: w_ptr_bin goes from 2**(ADDR_WIDTH+1)-1 to 0. The wrap bit toggles each time w_addr wraps.
//  - Flags are computed from w_ptr_next (the post-increment value), so they are valid in the cycle after the write:
//    - level_next = w_ptr_next - rptr_sync, mod 2**(ADDR_WIDTH+1)
//    - full <= (level_next == DEPTH)
//    - almost_full <= (level_next >= DEPTH-AFULL_THRESH)
//    - level <= level_next
//  - Full latency: full rises on the same edge as the write that fills the last slot.
//    No accepted write ever exceeds DEPTH.
//  - Release latency: a change on r_ptr_gray is reflected in full/level on the (SYNC_STAGES+1)th rising edge after it.
//    The flags are conservative: stale data can only over-report occupancy.
//  - Overflow: wr_en=1 while full=1 -> write ignored, pointer held, overflow <= 1.
//    ovf_clr=1 -> overflow <= 0. If ovf_clr and a new overflow occur in the same cycle, set wins.
//  - Simultaneous write and read-pointer advance: level reflects both; net change is 0.
//  - Reset mid-operation: all state clears immediately without a clock edge. Any in-flight write is lost.
//    The read side must also be reset.
// STRUCTURE
//  - DataTypes package additions:
//    - parametrised pointer typedef (ADDR_WIDTH+1 bits)
//    - functions bin2gray() and gray2bin()
//    - localparam DEPTH helper
//  - Sub-module gray_ptr_sync: SYNC_STAGES-deep flop chain, async active-low reset, parametrised width.
//    Reusable for the read-side empty controller.
//  - Pointer/flag logic is a single always_ff plus combinational next-state logic.
//  - Elaboration-time assertions check the parameter ranges.
// TESTING  (defaults: ADDR_WIDTH=4, DEPTH=16, SYNC_STAGES=2, AFULL_THRESH=2)
//  1. Reset: hold reset=0, toggle wr_en -> every output 0; release and idle -> outputs still 0.
//  2. Fill: r_ptr_gray=0, wr_en=1 for 16 cycles.
//     -> level counts 1..16; almost_full=1 from level 14; full=1 after the 16th write; wr_accept=0 on the 17th cycle.
//  3. Overflow: while full, wr_en=1 for 3 cycles -> w_addr held at 0 and overflow=1.
//     Pulse ovf_clr together with wr_en=1 -> overflow stays 1. Next ovf_clr alone -> overflow=0.
//  4. Release: from full, change r_ptr_gray 5'b00000 -> 5'b00001.
//     -> full=0 and level=15 on the 3rd rising edge after the change, not earlier.
//  5. Wrap: a model reader trails the writer by 3 over 40 writes.
//     -> w_ptr_gray passes 5'b10000 (bin 31) -> 5'b00000; full never asserts; level stays consistent with the model.
//  6. Async reset mid-fill: at level=9, drop reset between clock edges.
//     -> level, full, almost_full and w_ptr_gray are 0 before the next edge.

Source files
------------

// File: rtl/wr_ptr_full_ctrl_pkg.sv
// Shared pointer types and Gray-code helpers for the UART async FIFO pointer controllers.
package wr_ptr_full_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int CODE_W         = 32;

  // Pointer type at the default geometry; modules declare their own sized copy from ADDR_WIDTH.
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Operate on zero-extended words so any pointer width up to CODE_W-1 can share one helper.
  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_ptr_full_ctrl_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module gray_ptr_sync
  import wr_ptr_full_ctrl_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-side pointer and full/almost-full/level/overflow controller for the processor->UART async FIFO.
module wr_ptr_full_ctrl
  import wr_ptr_full_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  uart_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  typedef logic [PW-1:0] wptr_t;

  localparam wptr_t FULL_LEVEL  = wptr_t'(DEPTH);
  localparam wptr_t AFULL_LEVEL = wptr_t'(DEPTH - AFULL_THRESH);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("wr_ptr_full_ctrl: ADDR_WIDTH must be in 1..30");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("wr_ptr_full_ctrl: SYNC_STAGES must be in 2..4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH >= DEPTH) begin : g_bad_afull_thresh
    $error("wr_ptr_full_ctrl: AFULL_THRESH must satisfy 1 <= AFULL_THRESH < DEPTH");
  end

  wptr_t              w_ptr_bin;
  wptr_t              w_ptr_next;
  wptr_t              r_sync_gray;
  wptr_t              rptr_sync;
  wptr_t              level_next;
  logic [CODE_W-1:0]  rptr_wide;
  logic [CODE_W-1:0]  gray_next_wide;
  logic               unused_code_bits;

  gray_ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (uart_clk),
    .rst_n (reset),
    .d     (r_ptr_gray),
    .q     (r_sync_gray)
  );

  // Handshake: a write is taken on the rising edge where wr_en=1 and wr_accept=1; wr_en while full
  // is dropped (not stalled) and only recorded in the sticky overflow flag.
  assign wr_accept = wr_en & ~full & reset;

  assign rptr_wide        = gray2bin(CODE_W'(r_sync_gray));
  assign rptr_sync        = rptr_wide[PW-1:0];
  assign w_ptr_next       = wr_accept ? w_ptr_bin + wptr_t'(1) : w_ptr_bin;
  assign gray_next_wide   = bin2gray(CODE_W'(w_ptr_next));
  // Extra wrap bit makes the modular difference range 0..DEPTH rather than aliasing full to empty.
  assign level_next       = w_ptr_next - rptr_sync;
  assign unused_code_bits = ^{rptr_wide[CODE_W-1:PW], gray_next_wide[CODE_W-1:PW]};

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      w_ptr_bin   <= '0;
      w_ptr_gray  <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
      overflow    <= 1'b0;
    end else begin
      w_ptr_bin   <= w_ptr_next;
      w_ptr_gray  <= gray_next_wide[PW-1:0];
      full        <= (level_next == FULL_LEVEL);
      almost_full <= (level_next >= AFULL_LEVEL);
      level       <= level_next;
      // A fresh overflow beats a simultaneous clear so no event is lost.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign w_addr = w_ptr_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Randomised scoreboard bench for wr_ptr_full_ctrl against a count-based FIFO occupancy model.
module tb_wr_ptr_full_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int AFT   = 2;

  // clock / reset
  logic       uart_clk = 1'b0;
  logic       reset    = 1'b0;
  logic       wr_en    = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic [4:0] r_ptr_gray = '0;

  logic       wr_accept;
  logic [3:0] w_addr;
  logic [4:0] w_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;

  always #5 uart_clk = ~uart_clk;

  wr_ptr_full_ctrl #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SYNC),
    .AFULL_THRESH (AFT)
  ) dut (
    .uart_clk    (uart_clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .ovf_clr     (ovf_clr),
    .r_ptr_gray  (r_ptr_gray),
    .wr_accept   (wr_accept),
    .w_addr      (w_addr),
    .w_ptr_gray  (w_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  // scoreboard state
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;
  logic [16:0] mon_got;
  logic [4:0]  prev_wg = '0;
  bit          saw_wrap = 0;

  // reference model: plain write/read counts, with reads becoming visible SYNC cycles late
  int wcnt;
  int rcnt;
  bit ovf_m;
  bit full_m;
  int rd_pipe[$];

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic reset_model();
    wcnt   = 0;
    rcnt   = 0;
    ovf_m  = 0;
    full_m = 0;
    rd_pipe.delete();
    for (int i = 0; i < SYNC; i++) rd_pipe.push_back(0);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check1(name, {wr_accept, full, almost_full, level, w_ptr_gray, w_addr, overflow}, 32'd0);
  endtask

  // driver: call at a negedge; drives one cycle, queues the post-edge expectation, returns at next negedge
  task automatic step(input bit wr, input bit clr, input bit rd);
    int          vis;
    int          lvl;
    bit          acc;
    logic [16:0] e;
    if (rd && rcnt < wcnt) rcnt++;
    wr_en      = wr;
    ovf_clr    = clr;
    r_ptr_gray = gray5(rcnt);
    acc = wr && !full_m;
    rd_pipe.push_back(rcnt);
    vis = rd_pipe.pop_front();
    if (wr && full_m) ovf_m = 1;
    else if (clr) ovf_m = 0;
    if (acc) wcnt++;
    lvl    = wcnt - vis;
    full_m = (lvl == DEPTH);
    e = {full_m, (lvl >= DEPTH - AFT), 5'(lvl), gray5(wcnt), 4'(wcnt % DEPTH), ovf_m};
    exp_q.push_back(e);
    #1;
    check1("wr_accept", 32'(wr_accept), 32'(acc));
    @(negedge uart_clk);
  endtask

  // monitor: compares registered outputs after every edge that has a queued expectation
  always @(posedge uart_clk) begin
    #1;
    if (prev_wg == 5'b10000 && w_ptr_gray == 5'b00000) saw_wrap = 1;
    prev_wg = w_ptr_gray;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {full, almost_full, level, w_ptr_gray, w_addr, overflow};
      n_cmp++;
      if (mon_got !== mon_exp) begin
        n_bad++;
        $display("FAIL outputs @%0t: got full=%b af=%b lvl=%0d wg=%b wa=%0d ovf=%b, expected full=%b af=%b lvl=%0d wg=%b wa=%0d ovf=%b",
                 $time, mon_got[16], mon_got[15], mon_got[14:10], mon_got[9:5], mon_got[4:1], mon_got[0],
                 mon_exp[16], mon_exp[15], mon_exp[14:10], mon_exp[9:5], mon_exp[4:1], mon_exp[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    reset_model();

    // reset held: outputs stay 0 while wr_en toggles
    repeat (2) @(negedge uart_clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge uart_clk);
      wr_en   = ~wr_en;
      ovf_clr = i[0];
      #1;
      check_all_zero("reset_hold");
    end
    @(negedge uart_clk);
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    reset   = 1'b1;
    repeat (3) step(0, 0, 0);

    // fill to full, then overflow, set-wins and clear
    repeat (16) step(1, 0, 0);
    repeat (3) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 1, 0);

    // release one slot; visible on the third edge
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);

    // drain to a 3-deep lag, then 40 writes with the reader trailing by 3
    guard = 0;
    while (wcnt - rcnt > 3 && guard < 100) begin
      step(0, 0, 1);
      guard++;
    end
    guard = 0;
    begin
      int writes;
      writes = 0;
      while (writes < 40 && guard < 400) begin
        bit w;
        w = ($urandom_range(0, 3) != 0);
        if (w) writes++;
        step(w, 0, (wcnt - rcnt >= 3));
        guard++;
      end
      check1("wrap_writes_done", 32'(writes), 32'd40);
    end
    check1("wrap_seen", 32'(saw_wrap), 32'd1);

    // random mixed traffic, biased towards filling so full and overflow are exercised
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
    end

    // clean reset, then async reset mid-fill at level 9
    reset = 1'b0;
    r_ptr_gray = '0;
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    #1;
    check_all_zero("reset_clean");
    reset_model();
    @(negedge uart_clk);
    reset = 1'b1;
    repeat (9) step(1, 0, 0);
    check1("midfill_level", 32'(level), 32'd9);
    wr_en = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge uart_clk);
    wr_en = 1'b0;
    reset = 1'b1;
    reset_model();
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 1), 0, $urandom_range(0, 1));
    end

    repeat (3) @(posedge uart_clk);
    #2;
    check1("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
